// File: rtl/div_ctrl_if.sv
// Handshake bundle between the divide sequencer (master) and the iterative divider (slave).
// The sequencer owns start/cancel and the latched operands; the divider returns ready and the result.
interface div_ctrl_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        div_cancel;
  logic        div_ready;
  logic [63:0] div_result;

  modport master (
    output div_start, div_signed, div_opa, div_opb, div_cancel,
    input  div_ready, div_result
  );

  modport slave (
    input  div_start, div_signed, div_opa, div_opb, div_cancel,
    output div_ready, div_result
  );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer for the multi-cycle DIV/DIVU divider: one divide per E-stage instruction,
// with flush cancel, divide-by-zero short cut, hang timeout and a one-shot HI/LO write.
module div_ctrl #(
  parameter int TIMEOUT_CYCLES = 48,
  parameter int CNT_W          = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_signed,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic              flush,
  input  logic              advance,
  div_ctrl_if.master        div,
  output logic              stall,
  output logic              hilo_we,
  output logic [63:0]       hilo_wdata,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      result;
  logic             accept;

  assign accept = (state == IDLE) && req_valid && !flush;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Flush outranks ready, and ready outranks the timeout on the same RUN cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (b != 32'd0) ? RUN : DONE;
      RUN: begin
        if (flush)                state_nxt = IDLE;
        else if (div.div_ready)   state_nxt = DONE;
        else if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: if (advance || flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall      = accept || (state == RUN);
    hilo_we    = (state == DONE) && !flush;
    hilo_wdata = result;
  end

  // Operand latch, result capture and the one-cycle cancel/timeout pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      div.div_start  <= 1'b0;
      div.div_signed <= 1'b0;
      div.div_opa    <= 32'd0;
      div.div_opb    <= 32'd0;
      div.div_cancel <= 1'b0;
      result         <= 64'd0;
      cnt            <= '0;
      timeout_err    <= 1'b0;
    end else begin
      div.div_start  <= (state_nxt == RUN);
      div.div_cancel <= 1'b0;
      timeout_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            div.div_opa    <= a;
            div.div_opb    <= b;
            div.div_signed <= req_signed;
            cnt            <= '0;
            if (b == 32'd0) result <= {a, 32'hFFFF_FFFF};
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (flush) begin
            div.div_cancel <= 1'b1;
          end else if (div.div_ready) begin
            result <= div.div_result;
          end else if (cnt == CNT_LAST) begin
            div.div_cancel <= 1'b1;
            timeout_err    <= 1'b1;
            result         <= 64'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller for the iterative multi-cycle divider used by DIV/DIVU in the execute stage.
- Accepts a divide request from the E-stage ALU, latches the operands and drives the divider's start/cancel handshake.
- Produces the E-stage stall, then delivers a one-shot HI/LO write.
- Guarantees one divide per instruction; handles flush/exception cancel, divide-by-zero and a divider-hang timeout.

Parameters:
- TIMEOUT_CYCLES, 48: maximum RUN cycles to wait for div_ready before the divide is aborted.
- CNT_W, 6: width of the RUN cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  E stage holds a DIV/DIVU
- req_signed  in  1  1 = DIV, 0 = DIVU
- a  in  32  dividend (rs)
- b  in  32  divisor (rt)
- flush  in  1  exception in M, or flushE; kills the E-stage instruction
- advance  in  1  E-stage instruction moves to M this cycle
- div_ready  in  1  divider result valid
- div_result  in  64  divider output {remainder, quotient}
- div_start  out  1  level request to the divider
- div_signed  out  1  signedness to the divider
- div_opa  out  32  latched dividend
- div_opb  out  32  latched divisor
- div_cancel  out  1  one-cycle abort pulse to the divider
- stall  out  1  stall request for E and earlier stages
- hilo_we  out  1  HI/LO write enable
- hilo_wdata  out  64  {HI = remainder, LO = quotient}
- timeout_err  out  1  one-cycle pulse when a divide is aborted by timeout

Behaviour:
- Reset (synchronous, rst = 1 at a rising edge): state = IDLE; div_start, div_signed, div_opa, div_opb, div_cancel, result register, counter and timeout_err all 0. Combinational outputs follow from IDLE: stall = 0, hilo_we = 0.
- Reset mid-RUN: drops div_start. No cancel pulse is issued, because the divider shares rst.
- States: IDLE, RUN, DONE.
- IDLE, entry: on req_valid & ~flush, latch a, b and req_signed into div_opa, div_opb and div_signed; clear the counter.
  - If b != 0: next state RUN, div_start = 1 from the next cycle.
  - If b == 0: no divider access; result = {a, 32'hFFFF_FFFF}; next state DONE.
- IDLE, flush: req_valid & flush means no action and stall = 0.
- RUN:
  - div_start is held at 1 (level protocol); the counter increments each cycle; stall = 1.
  - Flush has priority over ready: div_cancel = 1 for one cycle, div_start = 0, result discarded, next state IDLE.
  - Otherwise, on div_ready: capture div_result into the result register, div_start = 0, next state DONE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: div_cancel = 1, timeout_err = 1 for one cycle, result = 0, div_start = 0, next state DONE.
- DONE:
  - stall = 0.
  - hilo_we = ~flush (combinational); hilo_wdata = result register (stable throughout DONE).
  - Next state IDLE on advance or flush; otherwise hold DONE.
  - While in DONE the same instruction is never re-issued, even though req_valid stays high.
  - If DONE persists for several cycles (downstream stall), hilo_we stays high. HI/LO writes are idempotent, so this is acceptable.
- Stall equation: stall = (IDLE & req_valid & ~flush) | RUN. Stall rises in the same cycle the request appears (combinational) and falls in the cycle DONE is entered.
- Latency:
  - Divider path: 1 (IDLE) + N RUN cycles + DONE, where N counts the RUN cycles up to and including the one where div_ready is sampled.
  - Divide by zero: exactly 1 stall cycle.
- Back-to-back divides: DONE→IDLE on advance, and the next instruction's request is accepted in IDLE the following cycle.
- Simultaneous events:
  - flush + div_ready in RUN: cancel wins.
  - flush + advance in DONE: go to IDLE with hilo_we = 0.
  - flush on the timeout cycle: treated as flush, with no timeout_err.

Test Plan:
- DIV a = 0xFFFF_FFF9 (-7), b = 2, signed; divider model with ready after 33 cycles → stall high 34 cycles; hilo_we with hilo_wdata = {0xFFFF_FFFF, 0xFFFF_FFFD}; exactly one div_start rising edge.
- DIVU a = 100, b = 7 with advance held low for 3 cycles after DONE → hilo_wdata = {2, 14}; hilo_we held for 3 cycles; no second start; IDLE after advance.
- flush asserted in the 10th RUN cycle → div_cancel pulses once; div_start falls; hilo_we never asserted; stall low the next cycle.
- b = 0, a = 0x1234 → div_start never asserted; 1 stall cycle; hilo_wdata = {0x0000_1234, 0xFFFF_FFFF}.
- Divider model never asserts ready → after 48 RUN cycles, div_cancel and timeout_err pulse; hilo_wdata = 0; stall released.
- rst pulsed in mid-RUN → next cycle all outputs 0, state IDLE; a fresh request then completes normally.
